// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle over WIDTH cycles.
// Divide-by-zero and signed overflow finish on the launch edge.
module mul_div_unit #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [WIDTH-1:0]      operand_a,
  input  logic [WIDTH-1:0]      operand_b,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      result,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  wenable
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0]              fn_q, fn_d;
  logic                    sign_a_q, sign_a_d;
  logic                    sign_b_q, sign_b_d;
  logic [WIDTH-1:0]        opnd_q, opnd_d;
  logic [2*WIDTH-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]        result_q, result_d;
  logic [REG_ADDR_W-1:0]   rd_out_q, rd_out_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    wen_q, wen_d;

  logic                    a_signed_s, b_signed_s;
  logic                    a_neg_s, b_neg_s;
  logic [WIDTH-1:0]        a_abs_s, b_abs_s;
  logic                    div_zero_s, div_ovf_s;
  logic [WIDTH:0]          mul_sum_s;
  logic [2*WIDTH-1:0]      mul_next_s;
  logic [WIDTH:0]          rem_shift_s;
  logic                    div_fits_s;
  logic [WIDTH-1:0]        div_diff_s;
  logic [2*WIDTH-1:0]      div_next_s;
  logic [2*WIDTH-1:0]      acc_step_s;
  logic [2*WIDTH-1:0]      prod_s;
  logic [WIDTH-1:0]        quo_s, rem_s;
  logic [WIDTH-1:0]        final_s;

  // Operand decode and magnitude extraction for a launch request
  always_comb begin
    a_signed_s = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed_s = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg_s    = a_signed_s & operand_a[WIDTH-1];
    b_neg_s    = b_signed_s & operand_b[WIDTH-1];
    a_abs_s    = a_neg_s ? (~operand_a + {{(WIDTH-1){1'b0}}, 1'b1}) : operand_a;
    b_abs_s    = b_neg_s ? (~operand_b + {{(WIDTH-1){1'b0}}, 1'b1}) : operand_b;
    div_zero_s = funct3[2] && (operand_b == {WIDTH{1'b0}});
    div_ovf_s  = funct3[2] && !funct3[0] && (operand_a == MIN_NEG) &&
                 (operand_b == {WIDTH{1'b1}});
  end

  // One iteration of shift-add multiply or restoring divide; acc holds {hi, lo}
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                  (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next_s  = {mul_sum_s, acc_q[WIDTH-1:1]};
    rem_shift_s = acc_q[2*WIDTH-1:WIDTH-1];
    div_fits_s  = (rem_shift_s >= {1'b0, opnd_q});
    div_diff_s  = rem_shift_s[WIDTH-1:0] - opnd_q;
    if (div_fits_s) begin
      div_next_s = {div_diff_s, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {acc_q[2*WIDTH-2:0], 1'b0};
    end
    acc_step_s  = fn_q[2] ? div_next_s : mul_next_s;
    prod_s      = (sign_a_q ^ sign_b_q) ? (~acc_step_s + {{(2*WIDTH-1){1'b0}}, 1'b1})
                                        : acc_step_s;
    quo_s       = (sign_a_q ^ sign_b_q)
                  ? (~acc_step_s[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                  : acc_step_s[WIDTH-1:0];
    rem_s       = sign_a_q
                  ? (~acc_step_s[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1})
                  : acc_step_s[2*WIDTH-1:WIDTH];
    case (fn_q)
      3'b000:                 final_s = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: final_s = prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         final_s = quo_s;
      3'b110, 3'b111:         final_s = rem_s;
      default:                final_s = {WIDTH{1'b0}};
    endcase
  end

  // Control FSM next-state and datapath capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fn_d     = fn_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    wen_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          fn_d     = funct3;
          rd_out_d = rd_in;
          if (div_zero_s || div_ovf_s) begin
            if (div_zero_s) begin
              result_d = funct3[1] ? operand_a : {WIDTH{1'b1}};
            end else begin
              result_d = funct3[1] ? {WIDTH{1'b0}} : MIN_NEG;
            end
            done_d  = 1'b1;
            wen_d   = (rd_in != {REG_ADDR_W{1'b0}});
            state_d = S_DONE;
          end else begin
            sign_a_d = a_neg_s;
            sign_b_d = b_neg_s;
            // multiplier or dividend sits in the low half; the other operand is held aside
            opnd_d   = funct3[2] ? b_abs_s : a_abs_s;
            acc_d    = {{WIDTH{1'b0}}, (funct3[2] ? a_abs_s : b_abs_s)};
            cnt_d    = {CW{1'b0}};
            busy_d   = 1'b1;
            state_d  = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        acc_d = acc_step_s;
        if (cnt_q == LAST_CNT) begin
          result_d = final_s;
          done_d   = 1'b1;
          wen_d    = (rd_out_q != {REG_ADDR_W{1'b0}});
          state_d  = S_DONE;
        end else begin
          cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          busy_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      fn_q     <= 3'b000;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= {WIDTH{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      result_q <= {WIDTH{1'b0}};
      rd_out_q <= {REG_ADDR_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fn_q     <= fn_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wen_q    <= wen_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign rd_out  = rd_out_q;
  assign wenable = wen_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed RV32M cases plus random
// operations compared against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        wenable;

  int vectors;
  int miscompares;

  mul_div_unit #(.WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .rd_in     (rd_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .wenable   (wenable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RV32M semantics straight from 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    t  = 64'h0;
    case (f)
      3'b000: begin t = sa * sb; return t[31:0]; end
      3'b001: begin t = sa * sb; return t[63:32]; end
      3'b010: begin t = sa * longint'(ub); return t[63:32]; end
      3'b011: begin t = ua * ub; return t[63:32]; end
      3'b100: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        t = sa / sb; return t[31:0];
      end
      3'b101: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'h0) return a;
        t = sa % sb; return t[31:0];
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && ((b == 32'h0) ||
                    (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit inject);
    int          cyc;
    int          done_cyc;
    int          busy_err;
    int          exp_lat;
    bit          spec;
    logic [31:0] exp_res, got_res;
    logic [4:0]  got_rd;
    logic        got_wen;
    spec    = is_special(f, a, b);
    exp_lat = spec ? 1 : 33;
    exp_res = model(f, a, b);
    got_res = 32'h0;
    got_rd  = 5'h0;
    got_wen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; funct3 = f; operand_a = a; operand_b = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0;
    operand_a = $urandom; operand_b = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
    cyc = 1; done_cyc = 0; busy_err = 0;
    while (done_cyc == 0 && cyc <= 40) begin
      if (busy !== (!spec && cyc <= 32)) busy_err++;
      if (done === 1'b1) begin
        done_cyc = cyc;
        got_res  = result;
        got_rd   = rd_out;
        got_wen  = wenable;
      end else begin
        if (inject && cyc == 10) begin
          start = 1'b1; funct3 = 3'b011; operand_a = $urandom; operand_b = $urandom;
          rd_in = 5'd9;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    check("done_cycle", 32'(done_cyc), 32'(exp_lat));
    check("busy_pattern", 32'(busy_err), 32'd0);
    check("result", got_res, exp_res);
    check("rd_out", {27'h0, got_rd}, {27'h0, rd});
    check("wenable", {31'h0, got_wen}, {31'h0, (rd != 5'd0)});
    @(posedge clk); #1;
    check("done_one_cycle", {31'h0, done}, 32'h0);
    check("result_held", result, exp_res);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [31:0] corner [4];
    bit          seen;
    vectors = 0; miscompares = 0;
    corner[0] = 32'h0; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h8000_0000; corner[3] = 32'h1;
    rst = 1'b1; start = 1'b0; funct3 = 3'b000; operand_a = 32'h0; operand_b = 32'h0; rd_in = 5'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_wenable", {31'h0, wenable}, 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_rd_out", {27'h0, rd_out}, 32'h0);
    rst = 1'b0;

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);
    check("mul_literal", result, 32'hFFFF_FFEB);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b0);
    check("mulh_literal", result, 32'h4000_0000);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
    check("mulhu_literal", result, 32'hFFFF_FFFE);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    check("mulhsu_literal", result, 32'hFFFF_FFFF);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0);
    check("div_literal", result, 32'hFFFF_FFFD);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
    check("rem_literal", result, 32'hFFFF_FFFF);
    run_op(3'b101, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b0);
    check("divu_literal", result, 32'h7FFF_FFFC);
    run_op(3'b111, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b0);
    check("remu_literal", result, 32'h1);
    run_op(3'b100, 32'd5, 32'd0, 5'd10, 1'b0);
    check("div_by_zero", result, 32'hFFFF_FFFF);
    run_op(3'b111, 32'd5, 32'd0, 5'd11, 1'b0);
    check("remu_by_zero", result, 32'd5);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
    check("div_overflow", result, 32'h8000_0000);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);
    check("rem_overflow", result, 32'h0);
    run_op(3'b000, 32'd123, 32'd456, 5'd0, 1'b0);

    // Abort a divide with reset mid-calculation
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b100; operand_a = 32'd100; operand_b = 32'd7; rd_in = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("abort_busy_before", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy_after", {31'h0, busy}, 32'h0);
    check("abort_result_reset", result, 32'h0);
    check("abort_rd_reset", {27'h0, rd_out}, 32'h0);
    seen = 1'b0;
    repeat (40) begin
      if (done === 1'b1 || wenable === 1'b1 || busy === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("abort_no_done", {31'h0, seen}, 32'h0);

    for (int i = 0; i < 40; i++) begin
      ra = (($urandom % 4) == 0) ? corner[$urandom % 4] : $urandom;
      rb = (($urandom % 4) == 0) ? corner[$urandom % 4] : $urandom;
      if (($urandom % 3) == 0) rb = rb >> ($urandom % 32);
      run_op(3'($urandom), ra, rb, 5'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
